mult_share_arbiter: RTL and testbench

//  Shares one WIDTH x WIDTH combinational multiplier (hardware_multiplier) between NREQ requesters.

---
 rtl/mult_share_arbiter.sv | 136 +++++++++++++
 tb/tb_mult_share_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Shares one combinational multiplier between NREQ valid/ready requesters.
// Define MULT_ARB_RR_EN for round-robin arbitration; otherwise fixed priority.
module mult_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ = 4,
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [2*WIDTH-1:0]    res_data,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [IDW-1:0]     r_op_id;
    logic [IDW-1:0]     w_ptr;
    logic [IDW-1:0]     w_gnt_id;
    logic               w_any;
    logic               w_grant;
    logic [2*WIDTH-1:0] w_prod;

`ifdef MULT_ARB_RR_EN
    logic [IDW-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            if (w_gnt_id == IDW'(NREQ - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= w_gnt_id + IDW'(1);
            end
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin : arb
        int idx;
        w_any    = 1'b0;
        w_gnt_id = '0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(w_ptr) + k) % NREQ;
            if (!w_any && req_valid[idx]) begin
                w_any    = 1'b1;
                w_gnt_id = IDW'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_grant     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready   = NREQ'(1) << w_gnt_id;
                    w_grant     = 1'b1;
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_prod = {{WIDTH{1'b0}}, r_op_a} * {{WIDTH{1'b0}}, r_op_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_id   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
        end else begin
            if (w_grant) begin
                r_op_a  <= req_a[w_gnt_id*WIDTH +: WIDTH];
                r_op_b  <= req_b[w_gnt_id*WIDTH +: WIDTH];
                r_op_id <= w_gnt_id;
            end
            if (r_state == S_MUL) begin
                res_data  <= w_prod;
                res_id    <= r_op_id;
                res_valid <= 1'b1;
            end else if (r_state == S_RESP && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (WIDTH=4, NREQ=4).
module tb_mult_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mult_share_arbiter #(.WIDTH(4), .NREQ(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
        .res_id(res_id),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] a,
                          input logic [3:0] b);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
    endtask

    // Entered one unit after a rising edge, FSM in IDLE, res_ready=1.
    task automatic xact(input string tag, input logic [3:0] exp_rdy,
                        input logic [1:0] exp_id, input logic [7:0] exp_data,
                        input bit drop);
        #1;
        chk({tag, "_ready"}, 16'(req_ready), 16'(exp_rdy));
        @(posedge clk); #1;
        if (drop) req_valid = req_valid & ~exp_rdy;
        chk({tag, "_mul_ready"}, 16'(req_ready), 16'h0);
        chk({tag, "_mul_busy"}, 16'(busy), 16'h1);
        chk({tag, "_mul_valid"}, 16'(res_valid), 16'h0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 16'(res_valid), 16'h1);
        chk({tag, "_data"}, 16'(res_data), 16'(exp_data));
        chk({tag, "_id"}, 16'(res_id), 16'(exp_id));
        @(posedge clk); #1;
        chk({tag, "_done_valid"}, 16'(res_valid), 16'h0);
        chk({tag, "_done_busy"}, 16'(busy), 16'h0);
    endtask

    initial begin
        logic [1:0] id;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #3;
        chk("rst_valid", 16'(res_valid), 16'h0);
        chk("rst_data", 16'(res_data), 16'h0);
        chk("rst_id", 16'(res_id), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_ready", 16'(req_ready), 16'h0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        // basic products
        set_op(0, 4'd3, 4'd5);
        req_valid = 4'b0001;
        xact("t1", 4'b0001, 2'd0, 8'd15, 1'b1);
        set_op(2, 4'd15, 4'd15);
        req_valid = 4'b0100;
        xact("t2_max", 4'b0100, 2'd2, 8'hE1, 1'b1);
        set_op(2, 4'd0, 4'd9);
        req_valid = 4'b0100;
        xact("t2_zero", 4'b0100, 2'd2, 8'd0, 1'b1);

        // pointer back to 0 before the contention sequence
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) set_op(i, 4'(i + 1), 4'd2);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
`ifdef MULT_ARB_RR_EN
            id = 2'(k % 4);
`else
            id = 2'd0;
`endif
            xact($sformatf("t3_%0d", k), 4'(1 << id), id,
                 8'(2 * (id + 1)), 1'b0);
        end
        req_valid = 4'b0000;

        // result held under backpressure
        set_op(1, 4'd7, 4'd6);
        set_op(0, 4'd3, 4'd5);
        req_valid = 4'b0010;
        res_ready = 1'b0;
        #1;
        chk("t4_ready", 16'(req_ready), 16'h2);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        chk("t4_mul_ready", 16'(req_ready), 16'h0);
        @(posedge clk); #1;
        chk("t4_valid", 16'(res_valid), 16'h1);
        chk("t4_data", 16'(res_data), 16'd42);
        chk("t4_id", 16'(res_id), 16'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", 16'(res_valid), 16'h1);
            chk("t4_hold_data", 16'(res_data), 16'd42);
            chk("t4_hold_id", 16'(res_id), 16'd1);
            chk("t4_hold_ready", 16'(req_ready), 16'h0);
            chk("t4_hold_busy", 16'(busy), 16'h1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_xfer_valid", 16'(res_valid), 16'h0);
        chk("t4_xfer_busy", 16'(busy), 16'h0);
        chk("t4_next_ready", 16'(req_ready), 16'h1);
        xact("t4_next", 4'b0001, 2'd0, 8'd15, 1'b1);

        // asynchronous reset while in MUL
        set_op(1, 4'd2, 4'd3);
        req_valid = 4'b0010;
        #1;
        chk("t5_ready", 16'(req_ready), 16'h2);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        chk("t5_in_mul", 16'(busy), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 16'(res_valid), 16'h0);
        chk("t5_async_busy", 16'(busy), 16'h0);
        chk("t5_async_data", 16'(res_data), 16'h0);
        @(posedge clk); #1;
        chk("t5_rst_valid", 16'(res_valid), 16'h0);
        rst_n = 1'b1;
        set_op(1, 4'd4, 4'd4);
        set_op(3, 4'd9, 4'd9);
        req_valid = 4'b1010;
        xact("t5_first", 4'b0010, 2'd1, 8'd16, 1'b1);
        xact("t5_second", 4'b1000, 2'd3, 8'd81, 1'b1);

        // request held across RESP is a second, single grant
        set_op(1, 4'd5, 4'd5);
        req_valid = 4'b0010;
        res_ready = 1'b0;
        #1;
        chk("t6_ready", 16'(req_ready), 16'h2);
        @(posedge clk); #1;
        chk("t6_mul_ready", 16'(req_ready), 16'h0);
        @(posedge clk); #1;
        chk("t6_valid", 16'(res_valid), 16'h1);
        chk("t6_data", 16'(res_data), 16'd25);
        chk("t6_resp_ready", 16'(req_ready), 16'h0);
        @(posedge clk); #1;
        chk("t6_resp_ready2", 16'(req_ready), 16'h0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("t6_idle_valid", 16'(res_valid), 16'h0);
        xact("t6_again", 4'b0010, 2'd1, 8'd25, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("t6_quiet_valid", 16'(res_valid), 16'h0);
            chk("t6_quiet_ready", 16'(req_ready), 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
